// File: rtl/ws2812b_pixel_feeder.sv
// Assembles byte writes into 24-bit GRB pixels and buffers them in a show-ahead FIFO for the encoder.
// A fill engine repeats the current colour N+1 times; full FIFO stalls the fill and drops direct pushes.
module ws2812b_pixel_feeder #(
    parameter  int DEPTH = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          ovf_clr,
    output logic [23:0]   pix_data,
    output logic          pix_latch,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            fill_latch_q, fill_latch_d;
    logic [7:0]      r_q, r_d;
    logic [7:0]      g_q, g_d;
    logic [7:0]      b_q, b_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    // Entry layout: {G, R, B, latch}
    logic [24:0]     mem_q [DEPTH];
    logic [24:0]     head;

    logic            full;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic [24:0]     push_dat;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_latch_d = fill_latch_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        push         = 1'b0;
        push_dat     = '0;
        ovf_set      = 1'b0;

        full = (level_q == LW'(DEPTH));
        pop  = (level_q != '0) && pix_ready;

        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    case (wr_addr)
                        2'd0: r_d = wr_data;
                        2'd1: g_d = wr_data;
                        2'd2: begin
                            b_d = wr_data;
                            if (!full) begin
                                push     = 1'b1;
                                push_dat = {g_q, r_q, wr_data, 1'b0};
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                        default: begin
                            state_d      = S_FILL;
                            cnt_d        = wr_data[6:0];
                            fill_latch_d = wr_data[7];
                        end
                    endcase
                end
            end
            S_FILL: begin
                // Host writes are locked out while painting; flag the loss.
                if (wr_en) begin
                    ovf_set = 1'b1;
                end
                if (!full) begin
                    push     = 1'b1;
                    push_dat = {g_q, r_q, b_q, (cnt_q == 7'd0) && fill_latch_q};
                    if (cnt_q == 7'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fill_latch_q <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_latch_q <= fill_latch_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // Storage needs no reset: it is only observed through the level-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_comb begin
        head      = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
        pix_data  = head[24:1];
        pix_latch = head[0];
        pix_valid = (level_q != '0);
        busy      = (state_q == S_FILL);
        level     = level_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_ws2812b_pixel_feeder.sv
// Bench for ws2812b_pixel_feeder: vector table, directed corner sequences and random traffic
// checked each cycle against a queue-based reference model.
module tb_ws2812b_pixel_feeder;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          ovf_clr = 1'b0;
    logic [23:0]   pix_data;
    logic          pix_latch;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          busy;
    logic [LW-1:0] level;
    logic          overflow;

    ws2812b_pixel_feeder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ovf_clr   (ovf_clr),
        .pix_data  (pix_data),
        .pix_latch (pix_latch),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pixel queue of {G,R,B,latch}, colour regs, fill engine as a remaining-count.
    logic [24:0] mq[$];
    logic [7:0]  mr, mg, mb;
    bit          mbusy, ml, movf;
    int          mcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mr = 0; mg = 0; mb = 0;
        mbusy = 0; ml = 0; movf = 0; mcnt = 0;
    endtask

    task automatic model_edge();
        bit          full, setv, dopush;
        logic [24:0] item;
        full   = (mq.size() == DEPTH);
        setv   = 0;
        dopush = 0;
        item   = '0;
        if (mbusy) begin
            if (wr_en) setv = 1;
            if (!full) begin
                dopush = 1;
                item   = {mg, mr, mb, (mcnt == 0) ? ml : 1'b0};
                if (mcnt == 0) mbusy = 0;
                else mcnt--;
            end
        end else if (wr_en) begin
            case (wr_addr)
                2'd0: mr = wr_data;
                2'd1: mg = wr_data;
                2'd2: begin
                    mb = wr_data;
                    if (!full) begin
                        dopush = 1;
                        item   = {mg, mr, wr_data, 1'b0};
                    end else begin
                        setv = 1;
                    end
                end
                default: begin
                    mbusy = 1;
                    mcnt  = int'(wr_data[6:0]);
                    ml    = wr_data[7];
                end
            endcase
        end
        if (mq.size() != 0 && pix_ready) void'(mq.pop_front());
        if (dopush) mq.push_back(item);
        movf = setv ? 1'b1 : (ovf_clr ? 1'b0 : movf);
    endtask

    task automatic model_check();
        logic [24:0] h;
        h = (mq.size() != 0) ? mq[0] : 25'd0;
        chk("m_level", 32'(level), 32'(mq.size()));
        chk("m_valid", 32'(pix_valid), 32'(mq.size() != 0));
        chk("m_data", 32'(pix_data), 32'(h[24:1]));
        chk("m_latch", 32'(pix_latch), 32'(h[0]));
        chk("m_busy", 32'(busy), 32'(mbusy));
        chk("m_ovf", 32'(overflow), 32'(movf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic drive(input logic en, input logic [1:0] a, input logic [7:0] d,
                         input logic rdy, input logic clr);
        wr_en = en; wr_addr = a; wr_data = d; pix_ready = rdy; ovf_clr = clr;
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  a;
        logic [7:0]  d;
        logic        rdy;
        logic        clr;
        int          lvl;
        logic        vld;
        logic [23:0] dat;
        logic        lat;
        logic        bsy;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int delivered, latched, enc_wait, max_lvl, guard;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_data", 32'(pix_data), 0);
        chk("rst_latch", 32'(pix_latch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // Colour assembly, then a 5-pixel latched fill into a stalled encoder, then drain.
        tbl.push_back('{1, 0, 8'h11, 0, 0, 0, 0, 24'h0, 0, 0, 0});
        tbl.push_back('{1, 1, 8'h22, 0, 0, 0, 0, 24'h0, 0, 0, 0});
        tbl.push_back('{1, 2, 8'h33, 0, 0, 1, 1, 24'h221133, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 24'h0, 0, 0, 0});
        tbl.push_back('{1, 3, 8'h84, 0, 0, 0, 0, 24'h0, 0, 1, 0});
        for (int i = 1; i <= 4; i++)
            tbl.push_back('{0, 0, 8'h00, 0, 0, i, 1, 24'h221133, 0, 1, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 5, 1, 24'h221133, 0, 0, 0});
        for (int i = 4; i >= 1; i--)
            tbl.push_back('{0, 0, 8'h00, 1, 0, i, 1, 24'h221133, (i == 1), 0, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 1, 24'h221133, 1, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 24'h0, 0, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            step();
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_valid", i), 32'(pix_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_data", i), 32'(pix_data), 32'(tbl[i].dat));
            chk($sformatf("v%0d_latch", i), 32'(pix_latch), 32'(tbl[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
        end

        // Overflow: direct push into a full FIFO, write during a stalled fill, clear.
        drive(1, 3, 8'h07, 0, 0); step();
        drive(0, 0, 8'h00, 0, 0); repeat (8) step();
        chk("full_level", 32'(level), 8);
        chk("full_busy", 32'(busy), 0);
        drive(1, 2, 8'h44, 0, 0); step();
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_level", 32'(level), 8);
        drive(0, 0, 8'h00, 0, 1); step();
        chk("clr_ovf", 32'(overflow), 0);
        drive(1, 3, 8'h00, 0, 0); step();
        chk("stall_busy", 32'(busy), 1);
        drive(1, 0, 8'h99, 0, 1); step();
        chk("busywr_ovf", 32'(overflow), 1);
        chk("busywr_level", 32'(level), 8);
        drive(0, 0, 8'h00, 1, 0); step();
        chk("stall_pop_level", 32'(level), 7);
        chk("stall_pop_busy", 32'(busy), 1);
        drive(0, 0, 8'h00, 0, 0); step();
        chk("stall_done_level", 32'(level), 8);
        chk("stall_done_busy", 32'(busy), 0);
        drive(0, 0, 8'h00, 1, 0); repeat (7) step();
        chk("busywr_colour", 32'(pix_data), 32'h221144);
        step();
        drive(0, 0, 8'h00, 0, 1); step();

        // Simultaneous push and pop at partial and full occupancy.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 2, 8'(i), 0, 0); step();
        end
        drive(1, 2, 8'h04, 1, 0); step();
        chk("pp3_level", 32'(level), 3);
        chk("pp3_head", 32'(pix_data), 32'h221102);
        for (int i = 5; i <= 9; i++) begin
            drive(1, 2, 8'(i), 0, 0); step();
        end
        chk("pp8_pre_level", 32'(level), 8);
        drive(1, 2, 8'h0A, 1, 0); step();
        chk("pp8_level", 32'(level), 7);
        chk("pp8_ovf", 32'(overflow), 1);
        drive(0, 0, 8'h00, 1, 1); repeat (8) step();
        chk("pp_drained", 32'(level), 0);

        // 128-pixel fill against an encoder that holds ready low for 80 cycles per pixel.
        drive(1, 3, 8'h7F, 1, 0); step();
        drive(0, 0, 8'h00, 0, 0);
        delivered = 0; latched = 0; enc_wait = 0; max_lvl = 0;
        for (int c = 0; c < 20000; c++) begin
            if (delivered == 128 && !busy && level == 0) break;
            pix_ready = (enc_wait == 0);
            if (pix_valid && pix_ready) begin
                delivered++;
                if (pix_latch) latched++;
                enc_wait = 80;
            end else if (enc_wait > 0) begin
                enc_wait--;
            end
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        chk("f128_delivered", 32'(delivered), 128);
        chk("f128_latched", 32'(latched), 0);
        chk("f128_ovf", 32'(overflow), 0);
        chk("f128_maxlvl_le8", 32'(max_lvl <= 8), 1);
        chk("f128_idle", 32'(busy), 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] a;
            logic [7:0] d;
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == 2'd3) d = d & 8'h8F;
            drive(($urandom_range(0, 3) == 0), a, d, 1'($urandom), ($urandom_range(0, 15) == 0));
            step();
        end
        guard = 0;
        drive(0, 0, 8'h00, 1, 0);
        while ((mbusy || mq.size() != 0) && guard < 300) begin
            step();
            guard++;
        end
        chk("rand_drain", 32'(guard < 300), 1);

        // Reset in the middle of a long fill.
        drive(1, 3, 8'h64, 1, 0); step();
        drive(0, 0, 8'h00, 1, 0); repeat (50) step();
        chk("midfill_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(pix_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_data", 32'(pix_data), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 2, 8'h5A, 0, 0); step();
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_data", 32'(pix_data), 32'h00005A);
        drive(0, 0, 8'h00, 0, 0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
